// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, FSM states and ALU ops shared by the multicycle core.
package mips_pkg;
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI, ALU_SLT, ALU_SLTU} alu_op_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/mc_grf.sv
// mc_grf: register file, two async read ports, one sync write port, $0 reads as zero.
module mc_grf #(
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREG_W-1:0] ra1,
  input  logic [NREG_W-1:0] ra2,
  input  logic              we,
  input  logic [NREG_W-1:0] wa,
  input  logic [31:0]       wd,
  output logic [31:0]       rd1,
  output logic [31:0]       rd2
);
  logic [31:0] regs [2**NREG_W];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 2**NREG_W; i++) regs[i] <= '0;
    else if (we && wa != '0) regs[wa] <= wd;
  assign rd1 = ra1 == '0 ? '0 : regs[ra1];
  assign rd2 = ra2 == '0 ? '0 : regs[ra2];
endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS core (FETCH/DECODE/EXEC/MEM/WB) with req/ready instruction and data ports.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          NREG_W   = 5,
  parameter bit          EN_SLT   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_en,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal
);
  localparam logic [4:0] RA = 5'd31;
  state_t state;
  alu_op_t alu_op;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rd1, rd2, pc4, imm_s, imm_z, alu_b, alu_y, wd;
  logic [5:0] op, funct;
  logic [NREG_W-1:0] rs_t, rt_t, rd_t, ra_t, dst, wa;
  logic is_r, is_slt, r_alu, is_jr, is_mem, legal, jal_wr;
  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign rs_t  = ir[21 +: NREG_W];
  assign rt_t  = ir[16 +: NREG_W];
  assign rd_t  = ir[11 +: NREG_W];
  assign ra_t  = RA[NREG_W-1:0];
  assign pc4   = pc + 32'd4;
  assign imm_s = sext16(ir[15:0]);
  assign imm_z = {16'h0, ir[15:0]};
  assign is_r   = op == OP_R;
  assign is_slt = EN_SLT && is_r && (funct == F_SLT || funct == F_SLTU);
  // The all-zero word (sll $0,$0,0) is accepted as a harmless R-type write to $0.
  assign r_alu  = is_r && (funct == F_ADDU || funct == F_SUBU || is_slt || ir == '0);
  assign is_jr  = is_r && funct == F_JR;
  assign is_mem = op == OP_LW || op == OP_SW;
  assign legal  = r_alu || is_jr || op inside {OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL};
  assign alu_op = is_r ? (funct == F_SUBU ? ALU_SUB : funct == F_SLT ? ALU_SLT :
                          funct == F_SLTU ? ALU_SLTU : ALU_ADD) :
                  op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD;
  assign alu_b  = is_r ? b : op == OP_ORI ? imm_z : imm_s;
  assign alu_y  = alu_op == ALU_SUB  ? a - alu_b :
                  alu_op == ALU_OR   ? a | alu_b :
                  alu_op == ALU_LUI  ? {ir[15:0], 16'h0} :
                  alu_op == ALU_SLT  ? {31'h0, $signed(a) < $signed(alu_b)} :
                  alu_op == ALU_SLTU ? {31'h0, a < alu_b} : a + alu_b;
  assign dst    = is_r ? rd_t : rt_t;
  assign jal_wr = state == S_DECODE && op == OP_JAL;
  assign wa     = jal_wr ? ra_t : dst;
  assign wd     = jal_wr ? pc4 : op == OP_LW ? mdr : alu_out;
  assign wb_en  = (jal_wr || state == S_WB) && wa != '0;
  mc_grf #(.NREG_W(NREG_W)) u_grf (
    .clk(clk), .reset(reset), .ra1(rs_t), .ra2(rt_t),
    .we(wb_en), .wa(wa), .wd(wd), .rd1(rd1), .rd2(rd2)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) begin
          ir    <= imem_rdata;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rd1;
          b <= rd2;
          if (op == OP_J || op == OP_JAL) begin
            pc    <= {pc4[31:28], ir[25:0], 2'b00};
            state <= S_FETCH;
          end else state <= S_EXEC;
        end
        S_EXEC: begin
          alu_out <= alu_y;
          if (!legal || is_jr || op == OP_BEQ) begin
            pc    <= !legal ? pc4 : is_jr ? a : a == b ? pc4 + {imm_s[29:0], 2'b00} : pc4;
            state <= S_FETCH;
          end else state <= is_mem ? S_MEM : S_WB;
        end
        S_MEM: if (dmem_ready) begin
          mdr   <= dmem_rdata;
          pc    <= op == OP_SW ? pc4 : pc;
          state <= op == OP_SW ? S_FETCH : S_WB;
        end
        S_WB: begin
          pc    <= pc4;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  // Requests decode straight from the state so an asynchronous reset drops them at once.
  assign imem_req   = reset && state == S_FETCH;
  assign imem_addr  = pc;
  assign dmem_req   = state == S_MEM;
  assign dmem_we    = dmem_req && op == OP_SW;
  assign dmem_addr  = dmem_req ? {alu_out[31:2], 2'b00} : '0;
  assign dmem_wdata = dmem_req ? b : '0;
  assign wb_pc      = wb_en ? pc : '0;
  assign wb_addr    = wb_en ? 5'(wa) : '0;
  assign wb_data    = wb_en ? wd : '0;
  assign illegal    = state == S_EXEC && !legal;
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: ISA-level reference model plus wait-state memory responders driving mips_multicycle.
module tb_mips_multicycle;
  logic clk, reset;
  logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, wb_en, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, wb_pc, wb_data;
  logic [4:0] wb_addr;

  mips_multicycle dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {int cyc; logic [31:0] pc; logic [4:0] a; logic [31:0] d;} wb_t;
  typedef struct {int cyc; logic [31:0] a;} fe_t;

  int vectors = 0, errors = 0;
  int iwait = 0, dwait = 0;
  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] m_dmem [logic [31:0]];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc, exp_wpc, exp_wd, exp_ma, exp_mwd;
  logic [4:0] exp_wa;
  bit exp_wb, exp_ill, exp_mem, exp_we, have_prev;
  int exp_cyc, icnt, cyc, wb_seen, ill_seen;
  wb_t wb_q[$];
  fe_t fq[$];
  logic [31:0] ill_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_imem(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'h0;
  endfunction
  function automatic logic [31:0] rd_dmem(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 32'h0;
  endfunction
  function automatic logic [31:0] rd_mdmem(input logic [31:0] a);
    return m_dmem.exists(a) ? m_dmem[a] : 32'h0;
  endfunction
  function automatic wb_t wb_at(input int i);
    wb_t z = '{-1, 32'h0, 5'h0, 32'h0};
    return i < wb_q.size() ? wb_q[i] : z;
  endfunction
  function automatic fe_t fe_at(input int i);
    fe_t z = '{-1, 32'h0};
    return i < fq.size() ? fq[i] : z;
  endfunction
  function automatic logic [31:0] ill_at(input int i);
    return i < ill_q.size() ? ill_q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic m_init();
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    m_pc = 32'h0000_3000;
    m_dmem.delete();
    have_prev = 0;
    icnt = 0;
    cyc = 0;
    exp_wb = 0;
    exp_ill = 0;
    exp_mem = 0;
    wb_q.delete();
    fq.delete();
    ill_q.delete();
  endtask

  // Executes one whole instruction at m_pc architecturally and records what the core must show.
  task automatic m_step();
    logic [31:0] w, pc4, sx, rs, rt, res, nxt;
    logic [4:0] dst;
    int base;
    w = rd_imem(m_pc);
    pc4 = m_pc + 4;
    sx = {{16{w[15]}}, w[15:0]};
    rs = m_reg[w[25:21]];
    rt = m_reg[w[20:16]];
    exp_wb = 0; exp_ill = 0; exp_mem = 0; exp_we = 0;
    exp_wpc = m_pc; dst = 0; res = 0; nxt = pc4; base = 4;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h21: begin dst = w[15:11]; res = rs + rt; end
        6'h23: begin dst = w[15:11]; res = rs - rt; end
        6'h08: begin nxt = rs; base = 3; end
        default: if (w != 0) begin exp_ill = 1; base = 3; end
      endcase
      6'h0D: begin dst = w[20:16]; res = rs | {16'h0, w[15:0]}; end
      6'h0F: begin dst = w[20:16]; res = {w[15:0], 16'h0}; end
      6'h23: begin
        exp_mem = 1; exp_ma = (rs + sx) & ~32'h3; dst = w[20:16];
        res = rd_mdmem(exp_ma); base = 5;
      end
      6'h2B: begin
        exp_mem = 1; exp_we = 1; exp_ma = (rs + sx) & ~32'h3; exp_mwd = rt;
        m_dmem[exp_ma] = rt;
      end
      6'h04: begin base = 3; nxt = rs == rt ? pc4 + (sx << 2) : pc4; end
      6'h02: begin base = 2; nxt = {pc4[31:28], w[25:0], 2'b00}; end
      6'h03: begin base = 2; nxt = {pc4[31:28], w[25:0], 2'b00}; dst = 31; res = pc4; end
      default: begin exp_ill = 1; base = 3; end
    endcase
    if (dst != 0) begin
      exp_wb = 1; exp_wa = dst; exp_wd = res; m_reg[dst] = res;
    end
    exp_cyc = base + (exp_mem ? dwait : 0);
    m_pc = nxt;
  endtask

  // Memory responders: ready after iwait/dwait stall cycles, data only valid with ready.
  initial begin
    int iwc = 0, dwc = 0;
    imem_ready = 0; dmem_ready = 0; imem_rdata = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      imem_ready = 0; imem_rdata = 32'hDEAD_BEEF;
      if (imem_req) begin
        if (iwc >= iwait) begin
          imem_ready = 1; imem_rdata = rd_imem(imem_addr); iwc = 0;
        end else iwc++;
      end else iwc = 0;
      dmem_ready = 0; dmem_rdata = 32'hDEAD_BEEF;
      if (dmem_req) begin
        if (dwc >= dwait) begin
          dmem_ready = 1; dwc = 0;
          if (dmem_we) dmem[dmem_addr] = dmem_wdata;
          else dmem_rdata = rd_dmem(dmem_addr);
        end else dwc++;
      end else dwc = 0;
    end
  end

  // Compare process: every cycle out of reset, outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        cyc++;
        chk("req_exclusive", {31'h0, imem_req & dmem_req}, 32'h0);
        if (imem_req) chk("imem_addr", imem_addr, m_pc);
        if (imem_req && imem_ready) begin
          if (have_prev) begin
            chk("cycles_per_instr", icnt, exp_cyc);
            chk("wb_count", wb_seen, {31'h0, exp_wb});
            chk("illegal_count", ill_seen, {31'h0, exp_ill});
          end
          fq.push_back('{cyc, imem_addr});
          m_step();
          icnt = 1; have_prev = 1; wb_seen = 0; ill_seen = 0;
        end else if (!imem_req) icnt++;
        if (wb_en) begin
          wb_seen++;
          wb_q.push_back('{cyc, wb_pc, wb_addr, wb_data});
          chk("wb_expected", {31'h0, exp_wb}, 32'h1);
          chk("wb_pc", wb_pc, exp_wpc);
          chk("wb_addr", {27'h0, wb_addr}, {27'h0, exp_wa});
          chk("wb_data", wb_data, exp_wd);
        end
        if (illegal) begin
          ill_seen++;
          ill_q.push_back(imem_addr);
          chk("illegal_expected", {31'h0, exp_ill}, 32'h1);
        end
        if (dmem_req) begin
          chk("dmem_expected", {31'h0, exp_mem}, 32'h1);
          chk("dmem_addr", dmem_addr, exp_ma);
          chk("dmem_we", {31'h0, dmem_we}, {31'h0, exp_we});
          if (exp_we) chk("dmem_wdata", dmem_wdata, exp_mwd);
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'h0, imem_req, dmem_req, dmem_we, wb_en, illegal}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0000_3000);
    chk("rst_dmem_bus", dmem_addr | dmem_wdata, 32'h0);
    chk("rst_wb_bus", wb_pc | wb_data | {27'h0, wb_addr}, 32'h0);
    m_init();
    reset = 1;
  endtask

  initial begin
    reset = 0;
    // Program 1: arithmetic, memory with 3 wait cycles, illegal ops, jal/jr, self-loop.
    imem.delete(); dmem.delete();
    imem[32'h3000] = 32'h3401_1234;
    imem[32'h3004] = 32'h3C02_8000;
    imem[32'h3008] = 32'h0042_1821;
    imem[32'h300C] = 32'h3401_0010;
    imem[32'h3010] = 32'hAC01_0004;
    imem[32'h3014] = 32'h8C04_0004;
    imem[32'h3018] = 32'hFC00_0000;
    imem[32'h301C] = 32'h0022_282A;
    imem[32'h3020] = 32'h0024_3023;
    imem[32'h3024] = 32'h0000_0000;
    imem[32'h3028] = 32'h0C00_0C40;
    imem[32'h3100] = 32'h03E0_0008;
    imem[32'h302C] = 32'h1000_FFFF;
    iwait = 0; dwait = 3;
    apply_reset();
    repeat (70) @(negedge clk);
    #3;
    chk("p1_first_fetch_cyc", fe_at(0).cyc, 1);
    chk("p1_first_fetch_addr", fe_at(0).a, 32'h3000);
    chk("p1_second_fetch_cyc", fe_at(1).cyc, 5);
    chk("p1_second_fetch_addr", fe_at(1).a, 32'h3004);
    chk("p1_wb_count", wb_q.size(), 7);
    chk("p1_ori_cyc", wb_at(0).cyc, 4);
    chk("p1_ori_pc", wb_at(0).pc, 32'h3000);
    chk("p1_ori_addr", {27'h0, wb_at(0).a}, 32'd1);
    chk("p1_ori_data", wb_at(0).d, 32'h0000_1234);
    chk("p1_lui_data", wb_at(1).d, 32'h8000_0000);
    chk("p1_addu_data", wb_at(2).d, 32'h0000_0000);
    chk("p1_addu_addr", {27'h0, wb_at(2).a}, 32'd3);
    chk("p1_lw_addr", {27'h0, wb_at(4).a}, 32'd4);
    chk("p1_lw_data", wb_at(4).d, 32'h0000_0010);
    chk("p1_lw_cycles", fe_at(6).cyc - fe_at(5).cyc, 8);
    chk("p1_sw_mem", rd_dmem(32'h4), 32'h0000_0010);
    chk("p1_illegal_count", ill_q.size(), 2);
    chk("p1_illegal0_pc", ill_at(0), 32'h3018);
    chk("p1_illegal1_pc", ill_at(1), 32'h301C);
    chk("p1_jal_data", wb_at(6).d, 32'h302C);
    chk("p1_jal_addr", {27'h0, wb_at(6).a}, 32'd31);
    // Program 2: jal/jr/j/beq loop with one fetch wait cycle per instruction.
    imem.delete(); dmem.delete();
    imem[32'h3000] = 32'h0C00_0C40;
    imem[32'h3100] = 32'h03E0_0008;
    imem[32'h3004] = 32'h0800_0C02;
    imem[32'h3008] = 32'h1000_FFFF;
    iwait = 1; dwait = 0;
    apply_reset();
    repeat (30) @(negedge clk);
    #3;
    chk("p2_first_fetch_cyc", fe_at(0).cyc, 2);
    chk("p2_jal_wb_cyc", wb_at(0).cyc, 3);
    chk("p2_jal_wb_pc", wb_at(0).pc, 32'h3000);
    chk("p2_jal_wb_data", wb_at(0).d, 32'h3004);
    chk("p2_fetch1", fe_at(1).a, 32'h3100);
    chk("p2_fetch2", fe_at(2).a, 32'h3004);
    chk("p2_fetch3", fe_at(3).a, 32'h3008);
    chk("p2_fetch4", fe_at(4).a, 32'h3008);
    chk("p2_beq_cycles", fe_at(4).cyc - fe_at(3).cyc, 4);
    // Program 3: reset while a store is stalled; the store must not land.
    imem.delete(); dmem.delete();
    imem[32'h3000] = 32'h3401_0055;
    imem[32'h3004] = 32'hAC01_0008;
    imem[32'h3008] = 32'h1000_FFFF;
    iwait = 0; dwait = 50;
    apply_reset();
    begin
      int n = 0;
      while (!dmem_req && n < 40) begin
        @(negedge clk); #1; n++;
      end
    end
    chk("p3_store_reached", {31'h0, dmem_req}, 32'h1);
    @(negedge clk); @(negedge clk);
    #3;
    reset = 0;
    #1;
    chk("p3_abort_reqs", {30'h0, imem_req, dmem_req}, 32'h0);
    chk("p3_abort_we", {31'h0, dmem_we}, 32'h0);
    chk("p3_abort_pc", imem_addr, 32'h3000);
    chk("p3_no_store", {31'h0, dmem.exists(32'h8)}, 32'h0);
    dwait = 0;
    apply_reset();
    repeat (20) @(negedge clk);
    #3;
    chk("p3_restart_cyc", fe_at(0).cyc, 1);
    chk("p3_restart_addr", fe_at(0).a, 32'h3000);
    chk("p3_store_after", rd_dmem(32'h8), 32'h0000_0055);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Next-generation MIPS core for the same ISA subset as the single-cycle CPU, rebuilt as a multi-cycle FSM datapath.
- Instruction and data memories sit outside the core and connect through req/ready handshakes, so the core tolerates wait-state memories.
- Only the register file stays internal.
- Sits as the CPU core under the lab top; the bench drives both memory ports.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NREG_W, 5, register-address width; the register file has 2**NREG_W entries. NREG_W < 5 truncates register fields to their low bits.
- EN_SLT, 0, when 1 also decodes slt (funct 6'h2A) and sltu (funct 6'h2B); when 0 these are illegal.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (= PC).
- imem_ready  in  1  fetch accepted; imem_rdata is valid in this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  {alu_result[31:2], 2'b00}.
- dmem_wdata  out  32  rt value.
- dmem_ready  in  1  access done; dmem_rdata is valid in this cycle for loads.
- dmem_rdata  in  32  load data.
- wb_en  out  1  one-cycle pulse per register write (trace port).
- wb_pc  out  32  PC of the writing instruction.
- wb_addr  out  5  destination register.
- wb_data  out  32  value written.
- illegal  out  1  one-cycle pulse when an undecodable instruction retires.

Behaviour:
- Reset (reset low, asynchronous):
  - PC=RESET_PC, state=FETCH, all GRF entries 0.
  - All outputs 0 except imem_addr, which equals PC.
  - Reset asserted mid-handshake drops req immediately; the aborted access has no side effects.
  - The first fetch is requested in the first cycle after reset is released.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - imem_req=1 and imem_addr=PC, held stable until imem_ready=1.
  - On ready: IR<=imem_rdata, then go to DECODE.
  - ready may be high in the same cycle req rises (zero-wait).
- DECODE:
  - A<=GRF[rs], B<=GRF[rt].
  - j: PC<=index32, go to FETCH.
  - jal: GRF[31]<=PC+4, PC<=index32, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - ALU computes the result; ALUOut<=result.
  - beq: PC<=(A==B) ? PC+4+(sext(imm)<<2) : PC+4, go to FETCH.
  - jr: PC<=A, go to FETCH.
  - lw/sw: address = A+sext(imm), go to MEM.
  - addu/subu/ori/lui/slt/sltu: go to WB.
  - Illegal opcode: pulse illegal, PC<=PC+4, go to FETCH.
- MEM:
  - dmem_req=1, with address, we and wdata held until dmem_ready=1.
  - sw: on ready, PC<=PC+4, go to FETCH.
  - lw: on ready, MDR<=dmem_rdata, go to WB.
- WB:
  - Write rd (R-type), or rt (ori, lui, lw); PC<=PC+4, go to FETCH.
- Immediates:
  - ori zero-extends imm.
  - lui produces imm<<16.
  - addu/subu are modulo 2**32 with no overflow trap.
- Write to $0: discarded, and wb_en stays 0 (also for jal when NREG_W truncates 31 to 0 — not possible at default).
- Trace port:
  - wb_en pulses in the same cycle as the write edge.
  - wb_pc = PC of the retiring instruction (before the update).
  - wb_addr is zero-extended to 5 bits.
- Cycles per instruction at zero-wait memory: j/jal 2, beq/jr/illegal 3, R-type/ori/lui 4, sw 4, lw 5. Each memory wait cycle adds 1.
- nop (all zeros = sll $0,$0,0) decodes as an R-type write to $0: 4 cycles, no wb_en.
- Only one outstanding request at a time; imem_req and dmem_req are never high together.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: R 6'h00, ori 6'h0D, lui 6'h0F, lw 6'h23, sw 6'h2B, beq 6'h04, j 6'h02, jal 6'h03.
  - funct constants: addu 6'h21, subu 6'h23, jr 6'h08, slt 6'h2A, sltu 6'h2B.
  - FSM state enum.
  - ALU op enum.
- Sub-module: mc_grf, with 2 async read ports, 1 sync write port, $0 hardwired to zero, async active-low clear.
- The FSM, datapath registers and ALU stay in mips_multicycle.

Test Plan:
- Reset release, imem_ready tied 1, program "ori $1,$0,0x1234": imem_addr=0x3000 in cycle 1; wb_en pulses in cycle 4 with wb_pc=0x3000, wb_addr=1, wb_data=0x00001234; next fetch address is 0x3004.
- "lui $2,0x8000; addu $3,$2,$2": wb_data=0x80000000, then 0x00000000; no trap.
- Preset $1=0x10, then "sw $1,4($0)" followed by "lw $4,4($0)", with dmem_ready delayed 3 cycles: dmem_addr=0x4, dmem_wdata=0x10, req held stable for 4 cycles; lw writes $4=0x10; total for lw is 8 cycles.
- "beq $0,$0,-1" at 0x3008: next fetch is 0x3008, taken after 3 cycles. Then "jal 0x3100" at 0x3000: wb $31=0x3004 and next fetch is 0x3100; "jr $31" returns to 0x3004.
- Drive opcode 6'h3F, and slt with EN_SLT=0: illegal pulses once; PC advances by 4; no wb_en.
- Assert reset low while dmem_req is high: req drops in the same cycle, no write is observed, and after release the fetch restarts at 0x3000.
